// File: rtl/duc_pkg.sv
// duc_pkg: shared widths, lane count, saturation limits and lane phase helper
package duc_pkg;

    localparam int PH_W  = 20;
    localparam int SMP_W = 32;
    localparam int LANES = 4;

    localparam logic signed [SMP_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [SMP_W-1:0] SAT_MIN = 32'sh8000_0000;

    // Phase of lane k within one output clock, wrapping modulo a full turn
    function automatic logic [PH_W-1:0] lane_phase(
        input logic [PH_W-1:0] acc,
        input logic [PH_W-1:0] poff,
        input logic [PH_W-1:0] pinc,
        input int              k
    );
        return acc + poff + PH_W'(k) * pinc;
    endfunction

endpackage

// File: rtl/duc_sincos_lut.sv
// duc_sincos_lut: sin/cos ROM with registered sin and cos read ports
module duc_sincos_lut #(
    parameter int ADDR_W = 10,
    parameter int AMP_W  = 16
) (
    input  logic                    clk,
    input  logic [ADDR_W-1:0]       addr_i,
    output logic signed [AMP_W-1:0] sin_o,
    output logic signed [AMP_W-1:0] cos_o
);

    localparam int N = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] QTR = ADDR_W'(N / 4);

    logic signed [AMP_W-1:0] rom [N];

    for (genvar n = 0; n < N; n++) begin : g_rom
        localparam real ANG = 2.0 * 3.14159265358979323846 * n / N;
        localparam int  VAL = $rtoi($floor($sin(ANG) * ((2.0 ** (AMP_W - 1)) - 1.0) + 0.5));
        assign rom[n] = AMP_W'(VAL);
    end

    // cos reads a quarter turn ahead of sin
    always_ff @(posedge clk) begin
        sin_o <= rom[addr_i];
        cos_o <= rom[addr_i + QTR];
    end

endmodule

// File: rtl/duc_quad.sv
// duc_quad: four-lane digital upconverter, real output y = I*cos - Q*sin
module duc_quad
    import duc_pkg::*;
#(
    parameter int LUT_ADDR_W = 10,
    parameter int AMP_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PH_W-1:0]         pinc,
    input  logic [PH_W-1:0]         poff,
    input  logic                    p_valid,
    input  logic                    valid_in,
    input  logic [2*SMP_W-1:0]      data_in,
    output logic signed [SMP_W-1:0] data_out_0,
    output logic signed [SMP_W-1:0] data_out_1,
    output logic signed [SMP_W-1:0] data_out_2,
    output logic signed [SMP_W-1:0] data_out_3,
    output logic                    valid_out
);

    localparam int PW = SMP_W + AMP_W;
    localparam int DW = PW + 1;
    localparam logic signed [DW-1:0] HALF = DW'(1) << (AMP_W - 2);

    logic [PH_W-1:0]         acc_q, acc_d, pinc_q, pinc_d, poff_q, poff_d;
    logic [LUT_ADDR_W-1:0]   addr_q [LANES];
    logic [LUT_ADDR_W-1:0]   addr_d [LANES];
    logic signed [SMP_W-1:0] i1_q, q1_q, i2_q, q2_q;
    logic                    v1_q, v2_q, v3_q;
    logic signed [AMP_W-1:0] sin_w [LANES];
    logic signed [AMP_W-1:0] cos_w [LANES];
    logic signed [PW-1:0]    pc_q [LANES];
    logic signed [PW-1:0]    ps_q [LANES];
    logic signed [DW-1:0]    rnd_d [LANES];
    logic signed [SMP_W-1:0] out_q [LANES];
    logic signed [SMP_W-1:0] out_d [LANES];

    // Settings load, accumulator advance by four samples, lane table addresses
    always_comb begin
        acc_d  = p_valid ? '0 : (valid_in ? acc_q + (pinc_q << 2) : acc_q);
        pinc_d = p_valid ? pinc : pinc_q;
        poff_d = p_valid ? poff : poff_q;
        for (int k = 0; k < LANES; k++)
            addr_d[k] = LUT_ADDR_W'(lane_phase(acc_q, poff_q, pinc_q, k) >> (PH_W - LUT_ADDR_W));
    end

    // S1: phase state, lane addresses and input sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            pinc_q <= '0;
            poff_q <= '0;
            i1_q   <= '0;
            q1_q   <= '0;
            v1_q   <= 1'b0;
            for (int k = 0; k < LANES; k++)
                addr_q[k] <= '0;
        end else begin
            acc_q  <= acc_d;
            pinc_q <= pinc_d;
            poff_q <= poff_d;
            i1_q   <= data_in[SMP_W-1:0];
            q1_q   <= data_in[2*SMP_W-1:SMP_W];
            v1_q   <= valid_in;
            for (int k = 0; k < LANES; k++)
                addr_q[k] <= addr_d[k];
        end
    end

    // S2: table read, one ROM per lane
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        duc_sincos_lut #(
            .ADDR_W (LUT_ADDR_W),
            .AMP_W  (AMP_W)
        ) u_lut (
            .clk    (clk),
            .addr_i (addr_q[k]),
            .sin_o  (sin_w[k]),
            .cos_o  (cos_w[k])
        );
    end

    // S2 sample alignment with the table read, S3 full-precision products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i2_q <= '0;
            q2_q <= '0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                pc_q[k] <= '0;
                ps_q[k] <= '0;
            end
        end else begin
            i2_q <= i1_q;
            q2_q <= q1_q;
            v2_q <= v1_q;
            v3_q <= v2_q;
            for (int k = 0; k < LANES; k++) begin
                pc_q[k] <= PW'(i2_q) * PW'(cos_w[k]);
                ps_q[k] <= PW'(q2_q) * PW'(sin_w[k]);
            end
        end
    end

    // S4: guarded difference, round half up, saturate when the upper bits are not all sign
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rnd_d[k] = (DW'(pc_q[k]) - DW'(ps_q[k]) + HALF) >>> (AMP_W - 1);
            out_d[k] = (&rnd_d[k][DW-1:SMP_W-1] || ~|rnd_d[k][DW-1:SMP_W-1]) ? rnd_d[k][SMP_W-1:0]
                     : (rnd_d[k][DW-1] ? SAT_MIN : SAT_MAX);
        end
    end

    // S4 output registers, held between valid samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            for (int k = 0; k < LANES; k++)
                out_q[k] <= '0;
        end else begin
            valid_out <= v3_q;
            if (v3_q)
                for (int k = 0; k < LANES; k++)
                    out_q[k] <= out_d[k];
        end
    end

    assign data_out_0 = out_q[0];
    assign data_out_1 = out_q[1];
    assign data_out_2 = out_q[2];
    assign data_out_3 = out_q[3];

endmodule

// File: tb/tb_duc_quad.sv
// tb_duc_quad: randomized and directed checks of duc_quad against a sample-level model
module tb_duc_quad;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] pinc, poff;
    logic        p_valid, valid_in;
    logic [63:0] data_in;
    logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
    logic        valid_out;
    logic [31:0] dout [4];

    duc_quad dut (
        .clk        (clk),
        .rst        (rst),
        .pinc       (pinc),
        .poff       (poff),
        .p_valid    (p_valid),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .data_out_3 (data_out_3),
        .valid_out  (valid_out)
    );

    assign dout[0] = data_out_0;
    assign dout[1] = data_out_1;
    assign dout[2] = data_out_2;
    assign dout[3] = data_out_3;

    always #5 clk = ~clk;

    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -LMAX - 1;

    int               n_chk = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               tbl [1024];
    logic             ev [0:4095];
    logic [3:0][31:0] ed [0:4095];
    logic [3:0][31:0] held;
    logic [19:0]      m_acc, m_pinc, m_poff;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One output sample from the mixing equation, rounded and saturated
    function automatic logic [31:0] lane(input logic [19:0] th, input logic [63:0] d);
        int     si, ci;
        longint i, q, y, r;
        si = int'(th[19:10]);
        ci = (si + 256) % 1024;
        i  = longint'($signed(d[31:0]));
        q  = longint'($signed(d[63:32]));
        y  = i * tbl[ci] - q * tbl[si];
        r  = (y + 16384) >>> 15;
        return r > LMAX ? 32'h7FFF_FFFF : (r < LMIN ? 32'h8000_0000 : r[31:0]);
    endfunction

    task automatic check_outputs();
        if (ev[cyc]) held = ed[cyc];
        chk("valid_out", valid_out, ev[cyc]);
        for (int k = 0; k < 4; k++) chk($sformatf("lane%0d", k), dout[k], held[k]);
    endtask

    task automatic step(input logic pv, input logic vi, input logic [19:0] pi_,
                        input logic [19:0] po_, input logic [63:0] d);
        logic [19:0] th;
        @(negedge clk);
        cyc++;
        check_outputs();
        rst      = 1'b0;
        p_valid  = pv;
        valid_in = vi;
        pinc     = pi_;
        poff     = po_;
        data_in  = d;
        if (vi) begin
            ev[cyc+4] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                th = m_acc + m_poff + 20'(k) * m_pinc;
                ed[cyc+4][k] = lane(th, d);
            end
        end
        if (pv) begin
            m_pinc = pi_;
            m_poff = po_;
            m_acc  = '0;
        end else if (vi) begin
            m_acc = m_acc + 20'(4) * m_pinc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        check_outputs();
        p_valid  = 1'b0;
        valid_in = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_valid", valid_out, 0);
        for (int k = 0; k < 4; k++) chk($sformatf("rst_lane%0d", k), dout[k], 0);
        for (int c = cyc + 1; c < 4096; c++) ev[c] = 1'b0;
        held   = '0;
        m_acc  = '0;
        m_pinc = '0;
        m_poff = '0;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, pinc, poff, {$urandom, $urandom});
    endtask

    task automatic lanes_are(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] e);
        chk({tag, "_0"}, data_out_0, a);
        chk({tag, "_1"}, data_out_1, b);
        chk({tag, "_2"}, data_out_2, c);
        chk({tag, "_3"}, data_out_3, e);
    endtask

    initial begin
        logic [63:0] d;
        for (int n = 0; n < 1024; n++)
            tbl[n] = $rtoi($floor($sin(2.0 * 3.14159265358979323846 * n / 1024.0) * 32767.0 + 0.5));
        for (int c = 0; c < 4096; c++) ev[c] = 1'b0;
        held     = '0;
        m_acc    = '0;
        m_pinc   = '0;
        m_poff   = '0;
        rst      = 1'b1;
        p_valid  = 1'b0;
        valid_in = 1'b0;
        pinc     = '0;
        poff     = '0;
        data_in  = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", valid_out, 0);
        lanes_are("reset", 0, 0, 0, 0);

        // zero phase, unity-ish cosine
        step(1, 0, 20'h0, 20'h0, 64'h0);
        step(0, 1, 20'h0, 20'h0, {32'h0, 32'h4000_0000});
        idle(4);
        lanes_are("dc", 32'h3FFF_8000, 32'h3FFF_8000, 32'h3FFF_8000, 32'h3FFF_8000);

        // quarter-turn increment, accumulator wraps every sample
        step(1, 0, 20'h40000, 20'h0, 64'h0);
        repeat (3) step(0, 1, 20'h40000, 20'h0, {32'h0, 32'h4000_0000});
        idle(4);
        lanes_are("quarter", 32'h3FFF_8000, 32'h0, 32'hC000_8000, 32'h0);

        // 45 degree offset with extreme inputs saturates positive
        step(1, 0, 20'h0, 20'h20000, 64'h0);
        step(0, 1, 20'h0, 20'h20000, {32'h8000_0000, 32'h7FFF_FFFF});
        idle(4);
        lanes_are("sat", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        // valid gaps preserved
        step(1, 0, 20'h01234, 20'h00100, 64'h0);
        step(0, 1, 0, 0, {$urandom, $urandom});
        step(0, 0, 0, 0, {$urandom, $urandom});
        step(0, 1, 0, 0, {$urandom, $urandom});
        step(0, 1, 0, 0, {$urandom, $urandom});
        step(0, 0, 0, 0, {$urandom, $urandom});
        idle(5);

        // settings change coincident with a sample
        step(1, 0, 20'h0A000, 20'h03000, 64'h0);
        step(0, 1, 0, 0, {$urandom, $urandom});
        step(1, 1, 20'h15555, 20'h7F000, {$urandom, $urandom});
        step(0, 1, 0, 0, {$urandom, $urandom});
        step(0, 1, 0, 0, {$urandom, $urandom});
        idle(5);

        // reset with three samples in flight
        step(1, 0, 20'h02000, 20'h0, 64'h0);
        repeat (3) step(0, 1, 0, 0, {$urandom, $urandom});
        do_reset();
        idle(6);
        chk("post_rst_valid", valid_out, 0);
        step(1, 0, 20'h03300, 20'h00055, 64'h0);
        step(0, 1, 0, 0, {32'h1234_5678, 32'h8765_4321});
        idle(5);

        // randomized traffic
        for (int j = 0; j < 400; j++) begin
            d = {$urandom, $urandom};
            case ($urandom % 8)
                0: d = {32'h8000_0000, 32'h7FFF_FFFF};
                1: d = {32'h7FFF_FFFF, 32'h8000_0000};
                default: ;
            endcase
            step(($urandom % 16) == 0, ($urandom % 3) != 0, 20'($urandom), 20'($urandom), d);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
